dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port 8-bit data_memory between two requesters: port 0 (CPU datapath) and port 1 (loader/debug).
- Arbitrates requests, sequences one memory access at a time and drives the memory's active-low write strobe, address and write data.
- Captures the registered read data and returns it with a one-cycle ack pulse to the winning requester.
- Sits directly between the requesters and the data_memory instance.

Parameters:
- ADDR_W, 8, address width of requester and memory ports.
- DATA_W, 8, data width.
- MEM_DEPTH, 32, number of valid memory locations; addresses >= MEM_DEPTH are rejected with err.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- req0 / req1  input  1  access request, port 0 / port 1.
- we0 / we1  input  1  1 = write, 0 = read.
- addr0 / addr1  input  ADDR_W  access address.
- wdata0 / wdata1  input  DATA_W  write data.
- ack0 / ack1  output  1  one-cycle completion pulse.
- rdata0 / rdata1  output  DATA_W  read data; valid while ack is high, held afterwards.
- err0 / err1  output  1  out-of-range flag; valid while ack is high.
- mem_w  output  1  memory write strobe, active low (0 = write, 1 = read).
- mem_addr  output  ADDR_W  memory address.
- mem_din  output  DATA_W  memory write data.
- mem_dout  input  DATA_W  memory read data, registered inside the memory (valid the cycle after the read edge).
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: rst_n low at a rising edge forces the following, regardless of current state:
  - state = IDLE, last_grant = 1
  - ack0/1 = 0, err0/1 = 0, rdata0/1 = 0
  - mem_w = 1, mem_addr = 0, mem_din = 0, busy = 0
- Outputs are registered, with no combinational input-to-output paths.
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE:
  - If any req is high, pick a winner and latch winner id, we, addr and wdata. The requester's inputs need only be stable in that sampled cycle.
  - Load mem_addr = addr and mem_din = wdata.
  - Set mem_w = 0 only for an in-range write; otherwise mem_w = 1.
  - Go to ACCESS.
- ACCESS: the memory commits the write or launches the read at the end of this cycle. Next, mem_w returns to 1. A read goes to CAPTURE; a write or any out-of-range access goes to RESP.
- CAPTURE: latch mem_dout into the winner's rdata at the end of the cycle, then go to RESP.
- RESP: the winner's ack = 1 for exactly this cycle; the other port's ack stays 0. Go to IDLE.
- Latency, counted from the IDLE edge that samples req, ack is high in:
  - cycle +2 for a write or out-of-range access;
  - cycle +3 for a read.
  - One access completes every 3 or 4 cycles.
- A req still high in the IDLE cycle after ack is treated as a new request. Requesters drop req in the cycle following ack if no further access is wanted.
- Out of range (addr >= MEM_DEPTH):
  - mem_w stays 1, so no write occurs.
  - rdata = 0 and err = 1 with ack.
  - In-range accesses return err = 0.
- Arbitration on simultaneous req0 and req1 is round-robin: the port not equal to last_grant wins, and last_grant updates at the grant. A single requester always wins immediately.
- rdata of the non-winning port is unchanged.
- Reset mid-operation: a write whose ACCESS cycle coincides with rst_n low still commits at that edge, because the memory has no reset. No ack is issued for it, and the FSM restarts in IDLE.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin arbitration as described above.
- Undefined: fixed priority, where port 0 always wins simultaneous requests. last_grant is still maintained but ignored for arbitration.

Test Plan:
- Reset release, then req0 = 1, we0 = 1, addr0 = 8'h05, wdata0 = 8'hA5. Required: mem_w = 0 for exactly one cycle with mem_addr = 05 and mem_din = A5, ack0 pulses 2 cycles after sampling, err0 = 0.
- Read back: req0 = 1, we0 = 0, addr0 = 8'h05. Required: ack0 3 cycles after sampling, rdata0 = A5. On a fresh memory, addr 8'h1F returns 8'h1F.
- req0 and req1 both held high for reads at addr 3 and addr 7. Required with DMEM_ARB_RR_EN: grants alternate 0,1,0,1, with rdata0 = 03 and rdata1 = 07. Required without it: only ack0 pulses while req0 stays high.
- req1 write to addr 8'h20 (= MEM_DEPTH). Required: mem_w never 0, ack1 with err1 = 1 and rdata1 = 0. A following read of addr 0x20 gives err1 = 1.
- rst_n driven low during CAPTURE of a port-1 read. Required: next cycle busy = 0, ack1 = 0, rdata1 = 0, mem_w = 1. A fresh req1 afterwards completes normally.
- req0 held high continuously for back-to-back reads. Required: ack0 every 4 cycles, with busy low for exactly the IDLE cycle between accesses.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the dmem_arbiter and the data_memory.
// slave = arbiter view, master = requester/memory side view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              err0;
  logic              err1;
  logic              mem_w;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    output ack0, ack1, rdata0, rdata1, err0, err1, mem_w, mem_addr, mem_din, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    input  ack0, ack1, rdata0, rdata1, err0, err1, mem_w, mem_addr, mem_din, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port registered data_memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic              oor_q, oor_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              mem_w_q, mem_w_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic              busy_q, busy_d;

  logic              grant1;
  logic              sel_we;
  logic              sel_oor;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_RR_EN
  // On a tie the port that did not win last time gets the grant.
  assign grant1 = bus.req1 & (~bus.req0 | ~last_grant_q);
`else
  assign grant1 = bus.req1 & ~bus.req0;
`endif

  assign sel_we    = grant1 ? bus.we1    : bus.we0;
  assign sel_addr  = grant1 ? bus.addr1  : bus.addr0;
  assign sel_wdata = grant1 ? bus.wdata1 : bus.wdata0;
  assign sel_oor   = {1'b0, sel_addr} >= DEPTH_L;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    we_d         = we_q;
    oor_d        = oor_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    mem_w_d      = mem_w_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          win_d        = grant1;
          last_grant_d = grant1;
          we_d         = sel_we;
          oor_d        = sel_oor;
          mem_addr_d   = sel_addr;
          mem_din_d    = sel_wdata;
          mem_w_d      = ~(sel_we & ~sel_oor);
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        mem_w_d = 1'b1;
        if (we_q || oor_q) begin
          // Writes and rejected accesses have nothing to capture; answer directly.
          ack0_d  = ~win_q;
          ack1_d  = win_q;
          err0_d  = oor_q & ~win_q;
          err1_d  = oor_q & win_q;
          if (oor_q && win_q)  rdata1_d = '0;
          if (oor_q && !win_q) rdata0_d = '0;
          state_d = RESP;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (win_q) rdata1_d = bus.mem_dout;
        else       rdata0_d = bus.mem_dout;
        ack0_d  = ~win_q;
        ack1_d  = win_q;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      win_q        <= 1'b0;
      we_q         <= 1'b0;
      oor_q        <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      mem_w_q      <= 1'b1;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      we_q         <= we_d;
      oor_q        <= oor_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      mem_w_q      <= mem_w_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.err0     = err0_q;
  assign bus.err1     = err1_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.mem_w    = mem_w_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a registered-read memory model
// preloaded with mem[i] = i; expectations are queued at drive time.
module tb_dmem_arbiter;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   wr_count;
  logic [7:0] last_wr_addr;
  logic [7:0] last_wr_din;
  logic [7:0] mem [256];

  typedef struct {
    bit         port;
    logic [7:0] rdata;
    bit         err;
    bit         chk_rd;
    int         exp_cyc;
  } exp_t;

  exp_t sb[$];

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial for (int i = 0; i < 256; i++) mem[i] = 8'(i);

  always @(posedge clk) begin
    if (bus.mem_w === 1'b0) mem[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= mem[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Write-strobe watcher and response scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_w === 1'b0) begin
      wr_count++;
      last_wr_addr = bus.mem_addr;
      last_wr_din  = bus.mem_din;
    end
    if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
      check("ack_onehot", {31'd0, bus.ack0 & bus.ack1}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_port", {31'd0, bus.ack1}, {31'd0, e.port});
        check("ack_cycle", cyc, e.exp_cyc);
        check("err", {31'd0, e.port ? bus.err1 : bus.err0}, {31'd0, e.err});
        if (e.chk_rd)
          check("rdata", {24'd0, e.port ? bus.rdata1 : bus.rdata0}, {24'd0, e.rdata});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  task automatic push(input bit p, input logic [7:0] rd, input bit er, input bit chk, input int ec);
    exp_t e;
    e.port = p; e.rdata = rd; e.err = er; e.chk_rd = chk; e.exp_cyc = ec;
    sb.push_back(e);
  endtask

  // Single access from IDLE; requester inputs are valid only in the sampled cycle.
  task automatic access(input bit p, input bit w, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, input bit exp_err);
    int lat;
    lat = (w || a >= 8'd32) ? 2 : 3;
    push(p, exp_rd, exp_err, !w || exp_err, cyc + lat);
    if (p) begin bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; end
    else   begin bus.req0 = 1'b1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; end
    step();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.addr0 = 8'hEE; bus.addr1 = 8'hEE; bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;
    bus.we0 = ~w; bus.we1 = ~w;
    drain("access_timeout", 10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0, c0;
    n_checks = 0; n_fail = 0; wr_count = 0;
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    repeat (3) step();

    check("rst_ack0",   {31'd0, bus.ack0}, 32'd0);
    check("rst_ack1",   {31'd0, bus.ack1}, 32'd0);
    check("rst_err0",   {31'd0, bus.err0}, 32'd0);
    check("rst_err1",   {31'd0, bus.err1}, 32'd0);
    check("rst_rdata0", {24'd0, bus.rdata0}, 32'd0);
    check("rst_rdata1", {24'd0, bus.rdata1}, 32'd0);
    check("rst_mem_w",  {31'd0, bus.mem_w}, 32'd1);
    check("rst_addr",   {24'd0, bus.mem_addr}, 32'd0);
    check("rst_din",    {24'd0, bus.mem_din}, 32'd0);
    check("rst_busy",   {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    step();

    w0 = wr_count;
    access(1'b0, 1'b1, 8'h05, 8'hA5, 8'h00, 1'b0);
    check("wr_strobe_cycles", wr_count - w0, 1);
    check("wr_addr", {24'd0, last_wr_addr}, 32'h05);
    check("wr_din",  {24'd0, last_wr_din},  32'hA5);

    access(1'b0, 1'b0, 8'h05, 8'h00, 8'hA5, 1'b0);
    access(1'b0, 1'b0, 8'h1F, 8'h00, 8'h1F, 1'b0);
    access(1'b1, 1'b0, 8'h0C, 8'h00, 8'h0C, 1'b0);
    check("rdata0_hold", {24'd0, bus.rdata0}, 32'h1F);

    // Both ports held high; last grant went to port 1.
    c0 = cyc;
`ifdef DMEM_ARB_RR_EN
    push(1'b0, 8'h03, 1'b0, 1'b1, c0 + 3);
    push(1'b1, 8'h07, 1'b0, 1'b1, c0 + 7);
    push(1'b0, 8'h03, 1'b0, 1'b1, c0 + 11);
    push(1'b1, 8'h07, 1'b0, 1'b1, c0 + 15);
`else
    for (int k = 0; k < 4; k++) push(1'b0, 8'h03, 1'b0, 1'b1, c0 + 3 + 4 * k);
`endif
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h03;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h07;
    drain("arb_timeout", 40);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    step();

    w0 = wr_count;
    access(1'b1, 1'b1, 8'h20, 8'h5A, 8'h00, 1'b1);
    check("oor_no_write", wr_count - w0, 0);
    access(1'b1, 1'b0, 8'h0C, 8'h00, 8'h0C, 1'b0);
    access(1'b1, 1'b0, 8'h20, 8'h00, 8'h00, 1'b1);

    // Reset asserted during CAPTURE of a port-1 read.
    access(1'b1, 1'b0, 8'h0C, 8'h00, 8'h0C, 1'b0);
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h09;
    step();
    bus.req1 = 1'b0;
    step();
    check("capture_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_busy",   {31'd0, bus.busy}, 32'd0);
    check("mid_rst_ack1",   {31'd0, bus.ack1}, 32'd0);
    check("mid_rst_rdata1", {24'd0, bus.rdata1}, 32'd0);
    check("mid_rst_mem_w",  {31'd0, bus.mem_w}, 32'd1);
    step();
    access(1'b1, 1'b0, 8'h09, 8'h00, 8'h09, 1'b0);

    // Back-to-back reads with req0 held high: one access every 4 cycles.
    c0 = cyc;
    for (int k = 0; k < 3; k++) push(1'b0, 8'h1F, 1'b0, 1'b1, c0 + 3 + 4 * k);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h1F;
    for (int k = 1; k <= 11; k++) begin
      step();
      check("b2b_busy", {31'd0, bus.busy}, {31'd0, (k % 4) != 0});
    end
    bus.req0 = 1'b0;
    drain("b2b_timeout", 10);
    step();
    check("final_idle", {31'd0, bus.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
